card_shoe: RTL and testbench
============================

# card_shoe

Card-source responder for the blackjack game controller. It serves one card per request from a single 52-card shoe, drawing pseudo-randomly without replacement, and reshuffles automatically when the shoe is exhausted. It sits opposite the game FSM's draw-request path: the game pulses a request, and the shoe returns one card with a valid pulse.

## Interface
Parameters:
- LFSR_SEED, 16'hACE1: LFSR load value at reset, and the fallback value if the LFSR would become zero.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_req  in  1  draw request; sampled only in IDLE.
- i_seed_strobe  in  1  entropy strobe (deal button); mixes the LFSR.
- o_valid  out  1  one-cycle pulse; o_rank/o_suit hold the new card.
- o_rank  out  4  card rank, 1 (ace) to 13 (king); held until the next delivery.
- o_suit  out  2  card suit, 0 to 3; held until the next delivery.
- o_busy  out  1  high in every state except IDLE.
- o_cards_left  out  6  undealt cards, 0 to 52.
- o_reshuffled  out  1  one-cycle pulse when the shoe is refilled.

## Operation
- LFSR: 16-bit Fibonacci, taps 16/14/13/11. Advances every cycle.
- Stamp: 16-bit free-running counter.
- Seed strobe: on i_seed_strobe, lfsr <= next_lfsr ^ stamp. If that result is 0, load LFSR_SEED instead. The strobe is honoured in any state.
- Card index: idx, 0 to 51. rank = idx % 13 + 1; suit = idx / 13.
- used[51:0] bitmap: 1 means the card has been dealt.
- IDLE: on i_req, capture idx = lfsr[5:0], reduced by 52 if it is ≥ 52. Go to SEARCH.
- SEARCH: probe used[idx].
  - If 0, go to DELIVER.
  - If 1, idx <= (idx == 51) ? 0 : idx + 1, and stay in SEARCH. At most 52 probes, since at least one card is free.
- DELIVER: set used[idx], drive o_rank/o_suit, pulse o_valid, decrement o_cards_left.
  - If the new count is 0, go to SHUFFLE; otherwise go to IDLE.
- SHUFFLE: clear used, set o_cards_left = 52, pulse o_reshuffled, go to IDLE.
- i_req while o_busy is high is ignored (dropped, not queued). The requester waits for IDLE.
- i_req and i_seed_strobe in the same cycle: idx is taken from the pre-strobe LFSR value, and the strobe is applied on the same edge.
- Reset values:
  - State IDLE; lfsr = LFSR_SEED; stamp = 0; used = 0.
  - o_valid 0, o_rank 0, o_suit 0, o_busy 0, o_cards_left 52, o_reshuffled 0.
- Reset mid-SEARCH or mid-DELIVER aborts the draw: no o_valid, and the shoe is full again.

## Timing
- i_req is sampled at edge k. SEARCH occupies cycle k+1. o_valid is high in cycle k+2 if the first probe is free.
- Each used-card probe adds one cycle. Worst-case latency is 53 cycles.
- o_reshuffled is high in the cycle after the o_valid that delivered the 52nd card. o_busy stays high during that cycle.
- o_cards_left updates on the same edge that raises o_valid.
- All outputs are registered.

## Configuration
- Macro: SHOE_TRACK_USED_EN.
- Defined: behaviour as above (no replacement, bitmap, SHUFFLE state, variable latency).
- Undefined: draw with replacement.
  - The bitmap and SHUFFLE state are not built.
  - SEARCH always succeeds on its first probe, so latency is fixed at 2 cycles.
  - o_cards_left is constant 52; o_reshuffled is constant 0.

## Test plan
- Reset, then one i_req pulse → o_valid exactly 2 cycles later (LFSR_SEED gives idx 33 → rank 8, suit 2). o_cards_left = 51. o_busy is high for 2 cycles.
- 52 back-to-back requests, each issued when o_busy is low → 52 distinct (rank, suit) pairs. o_reshuffled pulses once, right after the 52nd o_valid. o_cards_left returns to 52.
- Force a collision by requesting a card whose idx is already used → latency grows by one cycle per consecutive used index, with wrap from 51 to 0 checked.
- i_req while o_busy is high, and i_req during SHUFFLE → ignored: no extra o_valid and no o_cards_left change.
- i_seed_strobe at a known stamp value → the LFSR equals next ^ stamp. A strobe that would zero the LFSR loads 16'hACE1. Simultaneous i_req uses the pre-strobe index.
- Assert i_reset mid-SEARCH → no o_valid, o_cards_left = 52, and the next draw behaves as after power-up. With SHOE_TRACK_USED_EN undefined, 60 requests all have 2-cycle latency and o_cards_left stays 52.

Source files
------------

// File: rtl/card_shoe_if.sv
// card_shoe_if: draw-request / card-delivery bundle between the game FSM (master)
// and the card shoe (slave).
interface card_shoe_if;
    logic       i_req;
    logic       i_seed_strobe;
    logic       o_valid;
    logic [3:0] o_rank;
    logic [1:0] o_suit;
    logic       o_busy;
    logic [5:0] o_cards_left;
    logic       o_reshuffled;
    modport master (
        output i_req, i_seed_strobe,
        input  o_valid, o_rank, o_suit, o_busy, o_cards_left, o_reshuffled
    );
    modport slave (
        input  i_req, i_seed_strobe,
        output o_valid, o_rank, o_suit, o_busy, o_cards_left, o_reshuffled
    );
endinterface

// File: rtl/card_shoe.sv
// card_shoe: serves one card per request from a 52-card shoe picked by a 16-bit LFSR.
// Define SHOE_TRACK_USED_EN for draws without replacement and automatic reshuffle.
module card_shoe #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic        i_clk,
    input logic        i_reset,
    card_shoe_if.slave shoe
);
    typedef enum logic [1:0] {IDLE, SEARCH, DELIVER, SHUFFLE} stateType;
    stateType    state;
    logic [15:0] lfsr, stamp, lfsrStep, lfsrMix;
    logic [5:0]  idx, reqIdx;
    logic [3:0]  idxRank;
    logic [1:0]  idxSuit;
    logic        probeHit;
`ifdef SHOE_TRACK_USED_EN
    logic [51:0] used;
`endif
    always_comb begin
        lfsrStep = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        lfsrMix  = shoe.i_seed_strobe ? lfsrStep ^ stamp : lfsrStep;
        reqIdx   = lfsr[5:0] >= 6'd52 ? lfsr[5:0] - 6'd52 : lfsr[5:0];
        idxSuit  = idx >= 6'd39 ? 2'd3 : idx >= 6'd26 ? 2'd2 : idx >= 6'd13 ? 2'd1 : 2'd0;
        idxRank  = 4'(idx - 6'd13 * {4'd0, idxSuit}) + 4'd1;
`ifdef SHOE_TRACK_USED_EN
        probeHit = used[idx];
`else
        probeHit = 1'b0;
`endif
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state             <= IDLE;
            lfsr              <= LFSR_SEED;
            stamp             <= '0;
            idx               <= '0;
            shoe.o_valid      <= 1'b0;
            shoe.o_rank       <= '0;
            shoe.o_suit       <= '0;
            shoe.o_busy       <= 1'b0;
            shoe.o_cards_left <= 6'd52;
            shoe.o_reshuffled <= 1'b0;
`ifdef SHOE_TRACK_USED_EN
            used              <= '0;
`endif
        end else begin
            stamp             <= stamp + 16'd1;
            lfsr              <= lfsrMix == 16'd0 ? LFSR_SEED : lfsrMix;
            shoe.o_valid      <= 1'b0;
            shoe.o_reshuffled <= 1'b0;
            case (state)
                IDLE: if (shoe.i_req) begin
                    idx         <= reqIdx;
                    state       <= SEARCH;
                    shoe.o_busy <= 1'b1;
                end
                // linear probe with wrap; at least one card is always free here
                SEARCH: if (probeHit) idx <= idx == 6'd51 ? 6'd0 : idx + 6'd1;
                else begin
                    state        <= DELIVER;
                    shoe.o_valid <= 1'b1;
                    shoe.o_rank  <= idxRank;
                    shoe.o_suit  <= idxSuit;
`ifdef SHOE_TRACK_USED_EN
                    used[idx]         <= 1'b1;
                    shoe.o_cards_left <= shoe.o_cards_left - 6'd1;
`endif
                end
                DELIVER: begin
                    state       <= IDLE;
                    shoe.o_busy <= 1'b0;
`ifdef SHOE_TRACK_USED_EN
                    if (shoe.o_cards_left == 6'd0) begin
                        state             <= SHUFFLE;
                        shoe.o_busy       <= 1'b1;
                        used              <= '0;
                        shoe.o_cards_left <= 6'd52;
                        shoe.o_reshuffled <= 1'b1;
                    end
`endif
                end
                default: begin
                    state       <= IDLE;
                    shoe.o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: directed checks of card_shoe; builds with or without SHOE_TRACK_USED_EN.
module tb_card_shoe;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef SHOE_TRACK_USED_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif
    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    card_shoe_if bus ();
    card_shoe dut (.i_clk(i_clk), .i_reset(i_reset), .shoe(bus));
    always #5 i_clk = ~i_clk;

    int checks = 0, passed = 0, validCount = 0, shuffleCount = 0, mLeft = 52;
    logic [15:0] mLfsr, mStamp;
    logic [51:0] mUsed = '0;

    function automatic logic [15:0] step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction
    function automatic int predIdx();
        return mLfsr[5:0] >= 6'd52 ? int'(mLfsr[5:0]) - 52 : int'(mLfsr[5:0]);
    endfunction

    // reference LFSR/stamp used to predict which card index each request picks
    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mLfsr  <= SEED;
            mStamp <= 16'd0;
        end else begin
            mLfsr  <= (step(mLfsr) ^ (bus.i_seed_strobe ? mStamp : 16'd0)) == 16'd0 ? SEED
                      : step(mLfsr) ^ (bus.i_seed_strobe ? mStamp : 16'd0);
            mStamp <= mStamp + 16'd1;
        end
    end
    always @(negedge i_clk) begin
        if (bus.o_valid) validCount++;
        if (bus.o_reshuffled) shuffleCount++;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic doReset(input logic withReq);
        bus.i_req = 1'b0;
        bus.i_seed_strobe = 1'b0;
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        bus.i_req = withReq;
        mUsed = '0;
        mLeft = 52;
    endtask

    task automatic draw(input int target, input bit poke, output int lat, output int gi);
        int want, n, c, budget;
        budget = 0;
        while (target >= 0 && predIdx() != target && budget < 2000) begin
            tick();
            budget++;
        end
        if (budget == 2000) begin
            checks++;
            $display("FAIL steer no idx %0d within %0d cycles", target, budget);
        end
        want = predIdx();
        n = 0;
        while (mUsed[want] && n < 52) begin
            want = want == 51 ? 0 : want + 1;
            n++;
        end
        bus.i_req = 1'b1;
        tick();
        bus.i_req = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b1) $display("FAIL draw_busy got %b want 1", bus.o_busy);
        else passed++;
        c = 1;
        while (bus.o_valid !== 1'b1 && c < 60) begin
            tick();
            c++;
        end
        lat = c;
        gi = int'(bus.o_suit) * 13 + int'(bus.o_rank) - 1;
        if (TRACK) begin
            mUsed[want] = 1'b1;
            mLeft--;
        end
        checks++;
        if (c != 2 + n) $display("FAIL draw_latency got %0d want %0d", c, 2 + n);
        else passed++;
        checks++;
        if ({bus.o_rank, bus.o_suit, bus.o_cards_left} !== {4'(want % 13 + 1), 2'(want / 13), 6'(mLeft)})
            $display("FAIL draw_card got r%0d s%0d left%0d want r%0d s%0d left%0d",
                     bus.o_rank, bus.o_suit, bus.o_cards_left, want % 13 + 1, want / 13, mLeft);
        else passed++;
        tick();
        if (mLeft == 0) begin
            mUsed = '0;
            mLeft = 52;
            checks++;
            if ({bus.o_valid, bus.o_reshuffled, bus.o_busy, bus.o_cards_left} !== {3'b011, 6'd52})
                $display("FAIL shuffle_cycle got v%b r%b b%b left%0d want v0 r1 b1 left52",
                         bus.o_valid, bus.o_reshuffled, bus.o_busy, bus.o_cards_left);
            else passed++;
            bus.i_req = poke;
            tick();
            bus.i_req = 1'b0;
        end
        checks++;
        if ({bus.o_valid, bus.o_reshuffled, bus.o_busy, bus.o_cards_left} !== {3'b000, 6'(mLeft)})
            $display("FAIL draw_idle got v%b r%b b%b left%0d want v0 r0 b0 left%0d",
                     bus.o_valid, bus.o_reshuffled, bus.o_busy, bus.o_cards_left, mLeft);
        else passed++;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({bus.o_valid, bus.o_rank, bus.o_suit, bus.o_busy, bus.o_cards_left, bus.o_reshuffled}
            !== {1'b0, 4'd0, 2'd0, 1'b0, 6'd52, 1'b0})
            $display("FAIL reset_outputs got v%b r%0d s%0d b%b left%0d sh%b want 0/0/0/0/52/0",
                     bus.o_valid, bus.o_rank, bus.o_suit, bus.o_busy, bus.o_cards_left, bus.o_reshuffled);
        else passed++;
    endtask

    // request sampled on the first edge after reset sees LFSR_SEED: idx 33 -> rank 8 suit 2
    task automatic test_first_draw(input string tag);
        doReset(1'b1);
        tick();
        bus.i_req = 1'b0;
        checks++;
        if ({bus.o_busy, bus.o_valid} !== 2'b10)
            $display("FAIL %s search_cycle got b%b v%b want b1 v0", tag, bus.o_busy, bus.o_valid);
        else passed++;
        tick();
        checks++;
        if ({bus.o_valid, bus.o_busy, bus.o_rank, bus.o_suit, bus.o_cards_left}
            !== {2'b11, 4'd8, 2'd2, TRACK ? 6'd51 : 6'd52})
            $display("FAIL %s deliver got v%b b%b r%0d s%0d left%0d want v1 b1 r8 s2 left%0d", tag,
                     bus.o_valid, bus.o_busy, bus.o_rank, bus.o_suit, bus.o_cards_left, TRACK ? 51 : 52);
        else passed++;
        tick();
        checks++;
        if ({bus.o_valid, bus.o_busy, bus.o_rank, bus.o_suit} !== {2'b00, 4'd8, 2'd2})
            $display("FAIL %s hold got v%b b%b r%0d s%0d want v0 b0 r8 s2", tag,
                     bus.o_valid, bus.o_busy, bus.o_rank, bus.o_suit);
        else passed++;
        if (TRACK) begin
            mUsed[33] = 1'b1;
            mLeft--;
        end
    endtask

    task automatic test_ignored();
        int v0;
        doReset(1'b1);
        v0 = validCount;
        tick();
        tick();
        tick();
        bus.i_req = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (validCount - v0 != 1) $display("FAIL busy_req_valids got %0d want 1", validCount - v0);
        else passed++;
        checks++;
        if ({bus.o_busy, bus.o_cards_left, bus.o_rank, bus.o_suit} !== {1'b0, TRACK ? 6'd51 : 6'd52, 4'd8, 2'd2})
            $display("FAIL busy_req_state got b%b left%0d r%0d s%0d want b0 left%0d r8 s2",
                     bus.o_busy, bus.o_cards_left, bus.o_rank, bus.o_suit, TRACK ? 51 : 52);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [51:0] seen;
        int lat, gi, s0;
        doReset(1'b0);
        seen = '0;
        s0 = shuffleCount;
        for (int i = 0; i < (TRACK ? 52 : 60); i++) begin
            draw(-1, 1'b1, lat, gi);
            if (gi >= 0 && gi < 52) seen[gi] = 1'b1;
        end
`ifdef SHOE_TRACK_USED_EN
        checks++;
        if (seen !== {52{1'b1}}) $display("FAIL distinct_cards got %h want all ones", seen);
        else passed++;
`endif
        checks++;
        if (shuffleCount - s0 != (TRACK ? 1 : 0))
            $display("FAIL reshuffle_pulses got %0d want %0d", shuffleCount - s0, TRACK ? 1 : 0);
        else passed++;
    endtask

`ifdef SHOE_TRACK_USED_EN
    // occupy 51, 0 and 1, then ask for 51 again: probes 51,0,1 collide, card 2 is served
    task automatic test_collision();
        int lat, gi;
        doReset(1'b0);
        draw(51, 1'b0, lat, gi);
        checks++;
        if (lat != 2 || gi != 51) $display("FAIL collide_first got lat%0d idx%0d want lat2 idx51", lat, gi);
        else passed++;
        draw(0, 1'b0, lat, gi);
        draw(1, 1'b0, lat, gi);
        draw(51, 1'b0, lat, gi);
        checks++;
        if (lat != 5 || gi != 2) $display("FAIL collide_wrap got lat%0d idx%0d want lat5 idx2", lat, gi);
        else passed++;
    endtask
`endif

    // stamp 1 strobe with a simultaneous request: idx from 0x59C3 (3), LFSR becomes 0xB386
    task automatic test_seed_strobe();
        doReset(1'b0);
        tick();
        bus.i_req = 1'b1;
        bus.i_seed_strobe = 1'b1;
        tick();
        bus.i_req = 1'b0;
        bus.i_seed_strobe = 1'b0;
        tick();
        checks++;
        if ({bus.o_valid, bus.o_rank, bus.o_suit} !== {1'b1, 4'd4, 2'd0})
            $display("FAIL strobe_pre_idx got v%b r%0d s%0d want v1 r4 s0", bus.o_valid, bus.o_rank, bus.o_suit);
        else passed++;
        tick();
        bus.i_req = 1'b1;
        tick();
        bus.i_req = 1'b0;
        tick();
        checks++;
        if ({bus.o_valid, bus.o_rank, bus.o_suit} !== {1'b1, 4'd1, 2'd2})
            $display("FAIL strobe_mix got v%b r%0d s%0d want v1 r1 s2", bus.o_valid, bus.o_rank, bus.o_suit);
        else passed++;
    endtask

    // pick strobe cycles (GF(2) solve) so that a strobe at edge T would zero the LFSR
    task automatic test_zero_strobe();
        localparam int T = 48;
        logic [15:0] basis [16];
        logic [63:0] comb [16];
        logic [15:0] v, goal;
        logic [63:0] c, pick;
        logic placed;
        for (int b = 0; b < 16; b++) begin
            basis[b] = '0;
            comb[b] = '0;
        end
        for (int t = 1; t < T; t++) begin
            v = 16'(t);
            for (int k = 0; k < T - t; k++) v = step(v);
            c = 64'd1 << t;
            placed = 1'b0;
            for (int b = 15; b >= 0; b--) if (!placed && v[b]) begin
                if (basis[b] == 16'd0) begin
                    basis[b] = v;
                    comb[b] = c;
                    placed = 1'b1;
                end else begin
                    v ^= basis[b];
                    c ^= comb[b];
                end
            end
        end
        goal = SEED;
        for (int k = 0; k <= T; k++) goal = step(goal);
        goal ^= 16'(T);
        pick = '0;
        for (int b = 15; b >= 0; b--) if (goal[b]) begin
            goal ^= basis[b];
            pick ^= comb[b];
        end
        doReset(1'b0);
        for (int t = 0; t < T; t++) begin
            bus.i_seed_strobe = pick[t];
            tick();
        end
        bus.i_seed_strobe = 1'b1;
        tick();
        bus.i_seed_strobe = 1'b0;
        bus.i_req = 1'b1;
        tick();
        bus.i_req = 1'b0;
        tick();
        checks++;
        if ({bus.o_valid, bus.o_rank, bus.o_suit} !== {1'b1, 4'd8, 2'd2})
            $display("FAIL zero_strobe got v%b r%0d s%0d want v1 r8 s2", bus.o_valid, bus.o_rank, bus.o_suit);
        else passed++;
    endtask

    task automatic test_reset_mid_search();
        int lat, gi, v0;
        doReset(1'b0);
        for (int i = 0; i < 3; i++) draw(-1, 1'b0, lat, gi);
        bus.i_req = 1'b1;
        tick();
        bus.i_req = 1'b0;
        v0 = validCount;
        #2 i_reset = 1'b1;
        #1;
        checks++;
        if ({bus.o_valid, bus.o_busy, bus.o_rank, bus.o_suit, bus.o_cards_left, bus.o_reshuffled}
            !== {2'b00, 4'd0, 2'd0, 6'd52, 1'b0})
            $display("FAIL abort_outputs got v%b b%b r%0d s%0d left%0d sh%b want 0/0/0/0/52/0",
                     bus.o_valid, bus.o_busy, bus.o_rank, bus.o_suit, bus.o_cards_left, bus.o_reshuffled);
        else passed++;
        tick();
        tick();
        checks++;
        if (validCount != v0) $display("FAIL abort_valid got %0d pulses want 0", validCount - v0);
        else passed++;
        test_first_draw("after_abort");
    endtask

    initial begin
        bus.i_req = 1'b0;
        bus.i_seed_strobe = 1'b0;
        test_reset();
        test_first_draw("first_draw");
        test_ignored();
        test_back_to_back();
`ifdef SHOE_TRACK_USED_EN
        test_collision();
`endif
        test_seed_strobe();
        test_zero_strobe();
        test_reset_mid_search();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
